// File: rtl/sipo_deserializer_pkg.sv
// Shared types and helpers for the serial-in/parallel-out deserializer.
// State encodings are fixed so that debug dumps match across stream stages.
package sipo_deserializer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHIFT  = 2'd1,
        ST_PARITY = 2'd2
    } state_e;

    // Bit-count register width: must represent 0..WIDTH inclusive.
    function automatic int unsigned cnt_width(input int unsigned w);
        return int'($clog2(w)) + 1;
    endfunction

endpackage

// File: rtl/sipo_deserializer_if.sv
// Serial input and parallel valid/ready output of the deserializer.
// slave = the deserializer, master = the producer/consumer around it.
interface sipo_deserializer_if #(
    parameter int unsigned WIDTH = 8
);
    logic             din;
    logic             din_valid;
    logic [WIDTH-1:0] dout;
    logic             dout_valid;
    logic             dout_ready;

    modport slave (
        input  din,
        input  din_valid,
        input  dout_ready,
        output dout,
        output dout_valid
    );

    modport master (
        output din,
        output din_valid,
        output dout_ready,
        input  dout,
        input  dout_valid
    );
endinterface

// File: rtl/sipo_out_reg.sv
// One-entry valid/ready holding register with sticky overrun on dropped loads.
// SIPO_PARITY_CHECK_EN adds a 1-bit flag stored alongside the data word.
module sipo_out_reg #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             load_valid,
    input  logic [WIDTH-1:0] load_data,
`ifdef SIPO_PARITY_CHECK_EN
    input  logic             load_flag,
    output logic             flag,
`endif
    input  logic             ready,
    output logic [WIDTH-1:0] data,
    output logic             valid,
    output logic             overrun
);

    logic [WIDTH-1:0] data_q, data_d;
    logic             valid_q, valid_d;
    logic             overrun_q, overrun_d;
    logic             fire;
`ifdef SIPO_PARITY_CHECK_EN
    logic             flag_q, flag_d;
`endif

    assign fire = valid_q && ready;

    // A load is accepted when the slot is empty or being drained on this edge.
    always_comb begin
        data_d    = data_q;
        valid_d   = valid_q;
        overrun_d = overrun_q;
`ifdef SIPO_PARITY_CHECK_EN
        flag_d    = flag_q;
`endif
        if (load_valid) begin
            if (!valid_q || fire) begin
                data_d  = load_data;
                valid_d = 1'b1;
`ifdef SIPO_PARITY_CHECK_EN
                flag_d  = load_flag;
`endif
            end else begin
                overrun_d = 1'b1;
            end
        end else if (fire) begin
            valid_d = 1'b0;
`ifdef SIPO_PARITY_CHECK_EN
            flag_d  = 1'b0;
`endif
        end
        if (clear) begin
            overrun_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data_q    <= '0;
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
`ifdef SIPO_PARITY_CHECK_EN
            flag_q    <= 1'b0;
`endif
        end else begin
            data_q    <= data_d;
            valid_q   <= valid_d;
            overrun_q <= overrun_d;
`ifdef SIPO_PARITY_CHECK_EN
            flag_q    <= flag_d;
`endif
        end
    end

    assign data    = data_q;
    assign valid   = valid_q;
    assign overrun = overrun_q;
`ifdef SIPO_PARITY_CHECK_EN
    assign flag    = flag_q;
`endif

endmodule

// File: rtl/sipo_deserializer.sv
// MSB-first serial-to-parallel word assembler feeding a one-entry output register.
// SIPO_PARITY_CHECK_EN: one extra even-parity bit per word, reported on parity_err.
module sipo_deserializer
    import sipo_deserializer_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   clear,
    sipo_deserializer_if.slave     bus,
    output logic [$clog2(WIDTH):0] bit_count,
    output logic                   overrun
`ifdef SIPO_PARITY_CHECK_EN
    ,
    output logic                   parity_err
`endif
);

    localparam int unsigned CNT_W = cnt_width(WIDTH);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] sr_q, sr_d;
    logic [WIDTH-1:0] shifted;
    logic [WIDTH-1:0] word;
    logic             word_done;
`ifdef SIPO_PARITY_CHECK_EN
    logic             word_perr;
`endif

    assign shifted = {sr_q[WIDTH-2:0], bus.din};

    // Next-state: sample din only on qualified edges; clear overrides everything.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        sr_d      = sr_q;
        word      = sr_q;
        word_done = 1'b0;
`ifdef SIPO_PARITY_CHECK_EN
        word_perr = 1'b0;
`endif
        case (state_q)
            ST_IDLE: begin
                if (bus.din_valid) begin
                    sr_d    = shifted;
                    cnt_d   = CNT_W'(1);
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (bus.din_valid) begin
                    sr_d = shifted;
                    if (cnt_q == CNT_W'(WIDTH - 1)) begin
`ifdef SIPO_PARITY_CHECK_EN
                        cnt_d     = CNT_W'(WIDTH);
                        state_d   = ST_PARITY;
`else
                        word      = shifted;
                        word_done = 1'b1;
                        cnt_d     = '0;
                        state_d   = ST_IDLE;
`endif
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
`ifdef SIPO_PARITY_CHECK_EN
            ST_PARITY: begin
                if (bus.din_valid) begin
                    word      = sr_q;
                    word_perr = (^sr_q) ^ bus.din;
                    word_done = 1'b1;
                    cnt_d     = '0;
                    state_d   = ST_IDLE;
                end
            end
`endif
            default: begin
                cnt_d   = '0;
                state_d = ST_IDLE;
            end
        endcase
        if (clear) begin
            sr_d      = '0;
            cnt_d     = '0;
            state_d   = ST_IDLE;
            word_done = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            sr_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sr_q    <= sr_d;
        end
    end

    assign bit_count = cnt_q;

    sipo_out_reg #(
        .WIDTH (WIDTH)
    ) u_out_reg (
        .clk        (clk),
        .reset      (reset),
        .clear      (clear),
        .load_valid (word_done),
        .load_data  (word),
`ifdef SIPO_PARITY_CHECK_EN
        .load_flag  (word_perr),
        .flag       (parity_err),
`endif
        .ready      (bus.dout_ready),
        .data       (bus.dout),
        .valid      (bus.dout_valid),
        .overrun    (overrun)
    );

endmodule

// File: tb/tb_sipo_deserializer.sv
// Directed + random bench for sipo_deserializer against a queue-based word model.
// Honours SIPO_PARITY_CHECK_EN when the same define is given to the RTL.
module tb_sipo_deserializer;

    localparam int unsigned W = 8;
`ifdef SIPO_PARITY_CHECK_EN
    localparam int unsigned PAR = 1;
`else
    localparam int unsigned PAR = 0;
`endif

    logic                 clk;
    logic                 rst;
    logic                 clear;
    logic [$clog2(W):0]   bit_count;
    logic                 overrun;
`ifdef SIPO_PARITY_CHECK_EN
    logic                 parity_err;
`endif

    sipo_deserializer_if #(.WIDTH(W)) bus ();

    sipo_deserializer #(
        .WIDTH (W)
    ) dut (
        .clk        (clk),
        .reset      (rst),
        .clear      (clear),
        .bus        (bus),
        .bit_count  (bit_count),
        .overrun    (overrun)
`ifdef SIPO_PARITY_CHECK_EN
        ,
        .parity_err (parity_err)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests;
    int fails;

    // Reference model: received bits of the partial word plus the held output slot.
    bit         partial[$];
    logic [W-1:0] m_dout;
    logic       m_valid;
    logic       m_ovr;
    logic       m_perr;

    task automatic model_reset();
        partial.delete();
        m_dout  = '0;
        m_valid = 1'b0;
        m_ovr   = 1'b0;
        m_perr  = 1'b0;
    endtask

    task automatic model_edge(input logic d, input logic dv, input logic rdy, input logic clr);
        logic         fire;
        logic         done;
        logic [W-1:0] w;
        logic         pe;
        fire = m_valid && rdy;
        done = 1'b0;
        w    = '0;
        pe   = 1'b0;
        if (clr) begin
            partial.delete();
            m_ovr = 1'b0;
        end else if (dv) begin
            partial.push_back(d);
            if (partial.size() == W + PAR) begin
                for (int i = 0; i < W; i++) w = {w[W-2:0], logic'(partial[i])};
                if (PAR != 0) pe = (^w) ^ partial[W];
                done = 1'b1;
                partial.delete();
            end
        end
        if (done) begin
            if (!m_valid || fire) begin
                m_dout  = w;
                m_valid = 1'b1;
                m_perr  = pe;
            end else begin
                m_ovr = 1'b1;
            end
        end else if (fire) begin
            m_valid = 1'b0;
            m_perr  = 1'b0;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string where);
        check({where, ".dout"},       32'(bus.dout),       32'(m_dout));
        check({where, ".dout_valid"}, 32'(bus.dout_valid), 32'(m_valid));
        check({where, ".bit_count"},  32'(bit_count),      32'(partial.size()));
        check({where, ".overrun"},    32'(overrun),        32'(m_ovr));
`ifdef SIPO_PARITY_CHECK_EN
        check({where, ".parity_err"}, 32'(parity_err),     32'(m_perr));
`endif
    endtask

    task automatic step(input string where, input logic d, input logic dv, input logic rdy, input logic clr);
        bus.din        = dv ? d : 1'bx;
        bus.din_valid  = dv;
        bus.dout_ready = rdy;
        clear          = clr;
        @(posedge clk);
        model_edge(d, dv, rdy, clr);
        #1;
        check_all(where);
    endtask

    // Sends one word MSB first; dout_ready is only high on the completing edge.
    task automatic send_word(input string where, input logic [W-1:0] w, input logic rdy_last,
                             input logic pbit);
        for (int i = 0; i < W; i++) begin
            step(where, w[W-1-i], 1'b1, (i == W - 1 && PAR == 0) ? rdy_last : 1'b0, 1'b0);
        end
        if (PAR != 0) step(where, pbit, 1'b1, rdy_last, 1'b0);
    endtask

    task automatic drain(input string where);
        step(where, 1'b0, 1'b0, 1'b1, 1'b0);
    endtask

    initial begin
        logic [W-1:0] wb2;
        tests = 0;
        fails = 0;
        wb2   = 8'hB2;

        // Reset with din undriven
        bus.din        = 1'bx;
        bus.din_valid  = 1'b0;
        bus.dout_ready = 1'b0;
        clear          = 1'b0;
        rst            = 1'b1;
        model_reset();
        #3;
        check_all("reset");
        #4 rst = 1'b0;

        for (int i = 0; i < 4; i++) step("idle", 1'b0, 1'b0, 1'b0, 1'b0);

        // Single word then one-cycle drain
        send_word("single", 8'hB2, 1'b0, ^wb2);
        drain("single_drain");

        // Gapped input: hold after 4 bits
        for (int i = 0; i < 4; i++) step("gap", wb2[W-1-i], 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) step("gap_hold", 1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 4; i < W; i++) step("gap", wb2[W-1-i], 1'b1, 1'b0, 1'b0);
        if (PAR != 0) step("gap", ^wb2, 1'b1, 1'b0, 1'b0);
        drain("gap_drain");

        // Overrun, then clear keeps the held word
        send_word("ovr_a", 8'hB2, 1'b0, ^wb2);
        send_word("ovr_b", 8'h5A, 1'b0, 1'b0);
        step("ovr_clear", 1'b1, 1'b1, 1'b0, 1'b1);
        step("ovr_after", 1'b0, 1'b0, 1'b0, 1'b0);
        drain("ovr_drain");

        // Complete and transfer on the same edge
        send_word("simul_a", 8'h0F, 1'b0, 1'b0);
        send_word("simul_b", 8'hF0, 1'b1, 1'b0);

        // Async reset mid-word with a word still held
        for (int i = 0; i < 5; i++) step("mid", 1'(i & 1), 1'b1, 1'b0, 1'b0);
        #2 rst = 1'b1;
        model_reset();
        #1;
        check_all("async_reset");
        #2 rst = 1'b0;
        send_word("fresh", 8'hA5, 1'b0, 1'b0);
        drain("fresh_drain");

`ifdef SIPO_PARITY_CHECK_EN
        send_word("par_ok", 8'hB2, 1'b0, 1'b0);
        drain("par_ok_drain");
        send_word("par_bad", 8'hB2, 1'b0, 1'b1);
        drain("par_bad_drain");
`endif

        // Random traffic
        for (int n = 0; n < 3000; n++) begin
            logic d, dv, rdy, clr;
            d   = 1'($urandom);
            dv  = ($urandom_range(0, 3) != 0);
            rdy = ($urandom_range(0, 2) == 0);
            clr = ($urandom_range(0, 60) == 0);
            step("rand", d, dv, rdy, clr);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
